// File: rtl/xor_stream_checksum_pkg.sv
// Shared definitions for the XOR stream checksum engine: FSM state
// encodings and fold-mode codes.
package xor_stream_checksum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic MODE_XOR    = 1'b0;
  localparam logic MODE_ROTXOR = 1'b1;

endpackage : xor_stream_checksum_pkg

// File: rtl/xor_stream_checksum_fold_step.sv
// One combinational fold step of the checksum: either plain XOR of the
// beat into the accumulator, or rotate the accumulator left by one bit
// and then XOR the beat in.
module xor_fold_step
  import xor_stream_checksum_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] data,
  input  logic         mode,
  output logic [N-1:0] next_acc
);

  logic [N-1:0] acc_rot;

  // Rotate-left-by-one view of the accumulator.
  assign acc_rot = {acc[N-2:0], acc[N-1]};

  // Select the fold flavour for this beat.
  always_comb begin
    next_acc = acc ^ data;
    if (mode == MODE_ROTXOR) begin
      next_acc = acc_rot ^ data;
    end
  end

endmodule : xor_fold_step

// File: rtl/xor_stream_checksum.sv
// Streaming XOR checksum engine. Folds N-bit beats of a packet into an
// accumulator and emits one checksum word, beat count and saturation flag
// per packet.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds valid (and its payload) until that edge; ready never
// depends combinationally on valid. in_ready is a pure function of state,
// out_valid is a pure function of state, and out_sum/out_count/out_ovf are
// registers that stay stable while out_valid is high.
module xor_stream_checksum
  import xor_stream_checksum_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf,
  output logic [1:0]    dbg_state
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q;
  logic [N-1:0]  fold_acc;
  logic [N-1:0]  next_acc;
  logic          fold_mode;
  logic          mode_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          accept;
  logic          fire_out;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign fire_out  = out_valid && out_ready;
  assign dbg_state = state_q;

  // The first beat of a packet folds into a zero accumulator with the live
  // mode input; later beats use the accumulator and the latched mode.
  assign fold_acc  = (state_q == IDLE) ? '0 : acc_q;
  assign fold_mode = (state_q == IDLE) ? mode : mode_q;

  xor_fold_step #(
    .N(N)
  ) u_fold (
    .acc      (fold_acc),
    .data     (in_data),
    .mode     (fold_mode),
    .next_acc (next_acc)
  );

  // Saturating beat counter and sticky overflow flag for the next beat.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == IDLE) begin
      cnt_d = CW'(1);
      ovf_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
      ovf_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Next-state logic for the IDLE -> ACCUM -> HOLD packet cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && in_last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fire_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, counter, latched mode and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_XOR;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      acc_q <= next_acc;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (state_q == IDLE) begin
        mode_q <= mode;
      end
    end else if (fire_out) begin
      ovf_q <= 1'b0;
    end
  end

  // Result registers, loaded on the last beat and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept && in_last) begin
      out_sum   <= next_acc;
      out_count <= cnt_d;
      out_ovf   <= ovf_d;
    end
  end

endmodule : xor_stream_checksum

// File: tb/tb_xor_stream_checksum.sv
// Directed testbench for xor_stream_checksum.
module tb_xor_stream_checksum;

  localparam int N  = 16;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_q[$];

  xor_stream_checksum #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation still running at 200us, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one beat, returns at the negedge after acceptance.
  task automatic send_beat(input logic [N-1:0] data, input logic last, input logic m);
    int budget;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("in_ready_before_beat", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = N'($urandom_range(0, 65535));
    mode     = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_data = N'($urandom_range(0, 65535));
      in_last = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  // Waits (bounded) for out_valid and compares the result against the queue head.
  task automatic check_result(input string tag, input logic [CW-1:0] exp_count, input logic exp_ovf);
    int budget;
    logic [N-1:0] exp_sum;
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    exp_sum = exp_q.pop_front();
    check({tag, "_sum"},   32'(out_sum),   32'(exp_sum));
    check({tag, "_count"}, 32'(out_count), 32'(exp_count));
    check({tag, "_ovf"},   32'(out_ovf),   32'(exp_ovf));
    check({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
  endtask

  // Completes the output handshake and checks the one-bubble return to IDLE.
  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after_hs"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = N'($urandom_range(0, 65535));
      in_last   = 1'($urandom_range(0, 1));
      mode      = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'h0000);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Plain XOR: 00FF ^ 0F0F ^ FFFF = F00F.
    exp_q.push_back(16'hF00F);
    send_beat(16'h00FF, 1'b0, 1'b0);
    send_beat(16'h0F0F, 1'b0, 1'b0);
    send_beat(16'hFFFF, 1'b1, 1'b0);
    check("xor_latency_out_valid", 32'(out_valid), 32'd1);
    check_result("xor", 8'd3, 1'b0);
    take_result("xor");

    // Rotate mode latched on beat 1: rotl(8001)=0003, ^0001 = 0002.
    exp_q.push_back(16'h0002);
    send_beat(16'h8001, 1'b0, 1'b1);
    send_beat(16'h0001, 1'b1, 1'b0);
    check_result("rot", 8'd2, 1'b0);
    take_result("rot");

    // Gaps, then backpressure: 1111 ^ 2222 ^ 4444 = 7777.
    exp_q.push_back(16'h7777);
    send_beat(16'h1111, 1'b0, 1'b0);
    idle_cycles(2);
    send_beat(16'h2222, 1'b0, 1'b1);
    idle_cycles(3);
    send_beat(16'h4444, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_sum",   32'(out_sum),   32'h7777);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("bp", 8'd3, 1'b0);
    take_result("bp");

    // Single-beat packet right after the handshake.
    exp_q.push_back(16'h1234);
    send_beat(16'h1234, 1'b1, 1'b0);
    check_result("single", 8'd1, 1'b0);
    take_result("single");

    // Saturation: 300 beats of 0001, even count folds to 0000.
    exp_q.push_back(16'h0000);
    for (int i = 1; i <= 300; i++) begin
      send_beat(16'h0001, (i == 300), 1'b0);
    end
    check_result("sat", 8'd255, 1'b1);
    take_result("sat");

    // Next packet reports no overflow.
    exp_q.push_back(16'h5A5A);
    send_beat(16'h5A5A, 1'b1, 1'b1);
    check_result("post_sat", 8'd1, 1'b0);
    take_result("post_sat");

    // Asynchronous reset between edges, mid-packet.
    send_beat(16'h0F00, 1'b0, 1'b0);
    send_beat(16'h00F0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_sum",   32'(out_sum),   32'h0000);
    check("arst_out_count", 32'(out_count), 32'd0);
    check("arst_out_ovf",   32'(out_ovf),   32'd0);
    check("arst_state",     32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q.push_back(16'h00AA);
    send_beat(16'h00AA, 1'b1, 1'b0);
    check_result("after_arst", 8'd1, 1'b0);
    take_result("after_arst");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_xor_stream_checksum
